// File: rtl/frv_pkg.sv
// Shared fetch-path types: halfword width, tagged halfword entry, and instruction length decode.
package frv_pkg;

    localparam int FRV_HW_W = 16;

    typedef struct packed {
        logic                err;
        logic [FRV_HW_W-1:0] hw;
    } frv_fetch_hw_t;

    // A halfword with low bits 2'b11 starts a 32-bit instruction.
    function automatic logic frv_is_32b(input logic [FRV_HW_W-1:0] hw);
        return (hw[1:0] == 2'b11);
    endfunction

endpackage

// File: rtl/frv_halfword_queue.sv
// In-order halfword queue for the fetch buffer: head at slot 0, push 1-2 at the tail, pop 1-2 at the head.
module frv_halfword_queue
    import frv_pkg::*;
#(
    parameter int BUF_HW = 6,
    parameter int CNT_W  = $clog2(BUF_HW + 1)
) (
    input  logic                 g_clk,
    input  logic                 g_resetn,
    input  logic                 clear,
    input  logic [1:0]           push_n,
    input  frv_fetch_hw_t        push_hw0,
    input  frv_fetch_hw_t        push_hw1,
    input  logic [1:0]           pop_n,
    output frv_fetch_hw_t        head0,
    output frv_fetch_hw_t        head1,
    output logic [CNT_W-1:0]     count
);

    localparam int IW = $clog2(BUF_HW);

    frv_fetch_hw_t    slots     [BUF_HW];
    frv_fetch_hw_t    slots_nxt [BUF_HW];
    logic [CNT_W-1:0] count_nxt;
    int               base;

    // Shift surviving entries down by the pop amount, then append behind them.
    always_comb begin
        slots_nxt = slots;
        for (int i = 0; i < BUF_HW; i++) begin
            if (i + int'(pop_n) < BUF_HW) begin
                slots_nxt[i] = slots[IW'(i + int'(pop_n))];
            end
        end
        base = int'(count) - int'(pop_n);
        if (push_n != 2'd0 && base >= 0 && base < BUF_HW) begin
            slots_nxt[IW'(base)] = push_hw0;
        end
        if (push_n == 2'd2 && base >= 0 && base + 1 < BUF_HW) begin
            slots_nxt[IW'(base + 1)] = push_hw1;
        end
        count_nxt = CNT_W'(base + int'(push_n));
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn || clear) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

    always_ff @(posedge g_clk) begin
        slots <= slots_nxt;
    end

    assign head0 = slots[0];
    assign head1 = slots[1];

endmodule

// File: rtl/frv_fetch_buffer.sv
// Instruction fetch buffer: halfword queue plus PC, misaligned-entry drop and length decode.
// Compressed (16-bit) instruction support is enabled by defining FRV_FETCH_RVC_EN.
module frv_fetch_buffer
    import frv_pkg::*;
#(
    parameter int          BUF_HW   = 6,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic [31:0] flush_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_error,
    output logic        mem_ready,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic        o_size,
    output logic [31:0] o_pc,
    output logic        o_error,
    input  logic        i_busy
);

    localparam int CNT_W = $clog2(BUF_HW + 1);

    logic [CNT_W-1:0] count;
    frv_fetch_hw_t    head0, head1, push_hw0, push_hw1;
    logic [1:0]       push_n, pop_n, pop_q;
    logic             drop_lo, accept, consume, has_two;
    logic [31:0]      pc;

    assign mem_ready = (count <= CNT_W'(BUF_HW - 2));
    assign accept    = mem_valid && mem_ready && !flush;
    assign consume   = o_valid && !i_busy && !flush;
    assign has_two   = (count >= CNT_W'(2));
    assign pop_q     = consume ? pop_n : 2'd0;
    assign o_pc      = pc;

    always_comb begin
        push_n   = 2'd0;
        push_hw0 = {mem_error, mem_rdata[15:0]};
        push_hw1 = {mem_error, mem_rdata[31:16]};
        if (accept) begin
            if (drop_lo) begin
                push_n   = 2'd1;
                push_hw0 = {mem_error, mem_rdata[31:16]};
            end else begin
                push_n = 2'd2;
            end
        end
    end

`ifdef FRV_FETCH_RVC_EN
    logic head_32, lone, held_lone;

    // A lone errored 32-bit head stays a lone emission until taken, so late appends cannot change o_instr.
    always_comb begin
        head_32 = frv_is_32b(head0.hw);
        lone    = head_32 && (!has_two || held_lone);
        o_valid = has_two || (count == CNT_W'(1) && (!head_32 || head0.err));
        o_size  = head_32;
        o_instr = 32'h0;
        o_error = 1'b0;
        pop_n   = 2'd0;
        if (o_valid) begin
            if (!head_32 || lone) begin
                o_instr = {16'h0, head0.hw};
                o_error = head0.err;
                pop_n   = 2'd1;
            end else begin
                o_instr = {head1.hw, head0.hw};
                o_error = head0.err | head1.err;
                pop_n   = 2'd2;
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn || flush) begin
            held_lone <= 1'b0;
        end else begin
            held_lone <= o_valid && i_busy && lone;
        end
    end
`else
    always_comb begin
        o_valid = has_two;
        o_size  = 1'b1;
        o_instr = 32'h0;
        o_error = 1'b0;
        pop_n   = 2'd0;
        if (o_valid) begin
            o_instr = {head1.hw, head0.hw};
            o_error = head0.err | head1.err;
            pop_n   = 2'd2;
        end
    end
`endif

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            pc      <= PC_RESET;
            drop_lo <= 1'b0;
        end else if (flush) begin
            pc <= flush_addr & ~32'h1;
`ifdef FRV_FETCH_RVC_EN
            drop_lo <= flush_addr[1];
`else
            drop_lo <= 1'b0;
`endif
        end else begin
            if (consume) begin
                pc <= pc + {29'h0, pop_n, 1'b0};
            end
            if (accept) begin
                drop_lo <= 1'b0;
            end
        end
    end

    frv_halfword_queue #(
        .BUF_HW (BUF_HW),
        .CNT_W  (CNT_W)
    ) u_queue (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .clear    (flush),
        .push_n   (push_n),
        .push_hw0 (push_hw0),
        .push_hw1 (push_hw1),
        .pop_n    (pop_q),
        .head0    (head0),
        .head1    (head1),
        .count    (count)
    );

endmodule
